// File: rtl/mcp3202_pkg.sv
// Shared types and constants for the MCP3202 ADC responder.
package mcp3202_pkg;

    localparam int unsigned CFG_BITS  = 3;
    localparam int unsigned DATA_BITS = 12;

    typedef logic [3:0] cnt_t;

    localparam cnt_t CFG_LAST  = cnt_t'(CFG_BITS - 1);
    localparam cnt_t DATA_LAST = cnt_t'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitStart,
        StCfg,
        StNullb,
        StDataMsb,
        StDataLsb,
        StTrail
    } state_e;

    // Conversion result for a given SGL/ODD selection; differential modes clamp at zero.
    function automatic logic [DATA_BITS-1:0] select_sample(
        input logic                 sgl,
        input logic                 odd,
        input logic [DATA_BITS-1:0] ch0,
        input logic [DATA_BITS-1:0] ch1
    );
        if (sgl) begin
            return odd ? ch1 : ch0;
        end
        if (!odd) begin
            return (ch0 > ch1) ? ch0 - ch1 : '0;
        end
        return (ch1 > ch0) ? ch1 - ch0 : '0;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses for one async input.
module sync_edge #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    // Shift chain plus one history flop; reset to the idle level so release makes no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {Stages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[Stages-2:0], din};
            prev_q <= sync_q[Stages-1];
        end
    end

    // Edges come from the last two synchronised samples.
    always_comb begin
        level = sync_q[Stages-1];
        rise  = sync_q[Stages-1] & ~prev_q;
        fall  = ~sync_q[Stages-1] & prev_q;
    end

endmodule

// File: rtl/mcp3202_responder.sv
// SPI slave that mimics an MCP3202 12-bit ADC: decodes start/config bits on DIN
// and returns a null bit plus the selected sample on DOUT.
module mcp3202_responder
    import mcp3202_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter bit          MSBF_ALLOWED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic [DATA_BITS-1:0] ch0_data,
    input  logic [DATA_BITS-1:0] ch1_data,
    output logic                 cfg_valid,
    output logic                 cfg_sgl,
    output logic                 cfg_odd,
    output logic                 busy
);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    sync_edge #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b0)
    ) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as sck so DIN is sampled in step with the detected rising edge.
    sync_edge #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .din   (mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_level, cs_rise, mosi_rise, mosi_fall};

    state_e               state_q;
    cnt_t                 bit_cnt_q;
    logic                 msbf_q;
    logic [DATA_BITS-1:0] sample_q;

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            msbf_q    <= 1'b0;
            sample_q  <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
            cfg_valid <= 1'b0;
            cfg_sgl   <= 1'b0;
            cfg_odd   <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            if (cs_level) begin
                // Deselect wins over everything: release the pad and abort.
                state_q <= StIdle;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q <= StWaitStart;
                            busy    <= 1'b1;
                        end
                    end
                    StWaitStart: begin
                        // Leading zeros before the start bit are skipped.
                        if (sck_rise && mosi_level) begin
                            state_q   <= StCfg;
                            bit_cnt_q <= '0;
                        end
                    end
                    StCfg: begin
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd0) begin
                                cfg_sgl <= mosi_level;
                            end else if (bit_cnt_q == 4'd1) begin
                                cfg_odd <= mosi_level;
                            end
                            if (bit_cnt_q == CFG_LAST) begin
                                // SGL and ODD are already registered by this edge.
                                msbf_q    <= mosi_level;
                                cfg_valid <= 1'b1;
                                sample_q  <= select_sample(cfg_sgl, cfg_odd, ch0_data, ch1_data);
                                state_q   <= StNullb;
                            end
                        end
                    end
                    StNullb: begin
                        if (sck_fall) begin
                            miso_oe   <= 1'b1;
                            miso      <= 1'b0;
                            bit_cnt_q <= DATA_LAST;
                            state_q   <= StDataMsb;
                        end
                    end
                    StDataMsb: begin
                        if (sck_fall) begin
                            miso <= sample_q[bit_cnt_q];
                            if (bit_cnt_q == 4'd0) begin
                                // B0 is shared; LSB-first readout resumes at B1.
                                if (!msbf_q && MSBF_ALLOWED) begin
                                    bit_cnt_q <= 4'd1;
                                    state_q   <= StDataLsb;
                                end else begin
                                    state_q <= StTrail;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 4'd1;
                            end
                        end
                    end
                    StDataLsb: begin
                        if (sck_fall) begin
                            miso <= sample_q[bit_cnt_q];
                            if (bit_cnt_q == DATA_LAST) begin
                                state_q <= StTrail;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StTrail: begin
                        if (sck_fall) begin
                            miso    <= 1'b0;
                            miso_oe <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3202_responder.sv
// Directed bench for mcp3202_responder: drives SPI transactions and checks DOUT bits.
`timescale 1ns/1ps
module tb_mcp3202_responder;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 10;  // clk cycles per SCK half period

    logic        clk = 1'b0;
    logic        reset;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [11:0] ch0_data;
    logic [11:0] ch1_data;
    logic        cfg_valid;
    logic        cfg_sgl;
    logic        cfg_odd;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cfg_pulses = 0;

    mcp3202_responder #(
        .SYNC_STAGES  (SYNC_STAGES),
        .MSBF_ALLOWED (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .ch0_data  (ch0_data),
        .ch1_data  (ch1_data),
        .cfg_valid (cfg_valid),
        .cfg_sgl   (cfg_sgl),
        .cfg_odd   (cfg_odd),
        .busy      (busy)
    );

    always #4 clk = ~clk;

    always @(posedge clk) begin
        if (cfg_valid === 1'b1) cfg_pulses++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        half_period();
        sck = 1'b1;
        half_period();
        sck = 1'b0;
    endtask

    task automatic send_cmd(input int lead, input logic sgl, input logic odd, input logic msbf);
        for (int i = 0; i < lead; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(sgl);
        send_bit(odd);
        send_bit(msbf);
        mosi = 1'b0;
    endtask

    // Master samples DOUT just before each rising edge.
    task automatic read_bits(input int n, output logic [63:0] rx, output int oe_hi);
        rx    = '0;
        oe_hi = 0;
        for (int i = 0; i < n; i++) begin
            half_period();
            rx = {rx[62:0], miso};
            if (miso_oe === 1'b1) oe_hi++;
            sck = 1'b1;
            half_period();
            sck = 1'b0;
        end
    endtask

    task automatic end_xfer(input string tag);
        cs_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
        check_eq({tag, "_oe_off"}, 64'(miso_oe), 64'd0);
        check_eq({tag, "_busy_off"}, 64'(busy), 64'd0);
        half_period();
    endtask

    // Full transaction: command, then n read bits including the null bit.
    task automatic xfer(input string tag, input int lead, input logic sgl, input logic odd,
                        input logic msbf, input int n, input logic [63:0] exp_rx);
        logic [63:0] rx;
        int          oe_hi;
        int          base;
        base = cfg_pulses;
        cs_n = 1'b0;
        half_period();
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        send_cmd(lead, sgl, odd, msbf);
        // Post-latch input changes must not leak into this readout.
        ch0_data = ~ch0_data;
        ch1_data = ~ch1_data;
        read_bits(n, rx, oe_hi);
        check_eq({tag, "_rx"}, rx, exp_rx);
        check_eq({tag, "_oe_bits"}, 64'(oe_hi), 64'(n));
        check_eq({tag, "_cfg_cnt"}, 64'(cfg_pulses - base), 64'd1);
        check_eq({tag, "_sgl"}, 64'(cfg_sgl), 64'(sgl));
        check_eq({tag, "_odd"}, 64'(cfg_odd), 64'(odd));
        end_xfer(tag);
    endtask

    initial begin : main
        logic [63:0] rx;
        int          oe_hi;
        int          base;

        reset    = 1'b1;
        sck      = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        ch0_data = 12'h000;
        ch1_data = 12'h000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("rst_miso", 64'(miso), 64'd0);
        check_eq("rst_oe", 64'(miso_oe), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_cfgv", 64'(cfg_pulses), 64'd0);
        check_eq("rst_sgl_odd", 64'({cfg_sgl, cfg_odd}), 64'd0);

        // Single-ended ch0, MSB first, four trailing zero bits.
        ch0_data = 12'hABC; ch1_data = 12'h555;
        xfer("se_ch0", 0, 1'b1, 1'b0, 1'b1, 17, 64'({1'b0, 12'hABC, 4'h0}));

        // Single-ended ch1 with a leading zero before the start bit.
        ch0_data = 12'hFFF; ch1_data = 12'h001;
        xfer("se_ch1", 1, 1'b1, 1'b1, 1'b1, 17, 64'({1'b0, 12'h001, 4'h0}));

        // Differential, saturating and non-saturating.
        ch0_data = 12'h100; ch1_data = 12'h200;
        xfer("diff_sat", 0, 1'b0, 1'b0, 1'b1, 13, 64'({1'b0, 12'h000}));
        ch0_data = 12'h100; ch1_data = 12'h200;
        xfer("diff_pos", 0, 1'b0, 1'b1, 1'b1, 13, 64'({1'b0, 12'h100}));

        // LSB-first tail after the MSB-first word.
        ch0_data = 12'h801; ch1_data = 12'h000;
        xfer("lsbf", 0, 1'b1, 1'b0, 1'b0, 26,
             64'({1'b0, 12'h801, 11'b00000000001, 2'b00}));

        // Abort inside the config phase: no cfg_valid.
        base = cfg_pulses;
        cs_n = 1'b0;
        half_period();
        send_bit(1'b1);
        send_bit(1'b1);
        end_xfer("abort_cfg");
        check_eq("abort_cfg_cnt", 64'(cfg_pulses - base), 64'd0);

        // Abort after six data bits, then a clean transaction.
        ch0_data = 12'hABC;
        cs_n = 1'b0;
        half_period();
        send_cmd(0, 1'b1, 1'b0, 1'b1);
        read_bits(7, rx, oe_hi);
        check_eq("abort_data_rx", rx, 64'({1'b0, 6'b101010}));
        check_eq("abort_data_oe_on", 64'(miso_oe), 64'd1);
        end_xfer("abort_data");
        ch0_data = 12'h000; ch1_data = 12'h3C5;
        xfer("after_abort", 0, 1'b1, 1'b1, 1'b1, 13, 64'({1'b0, 12'h3C5}));

        // Asynchronous reset in the middle of the data phase.
        ch0_data = 12'h000; ch1_data = 12'hFFF;
        cs_n = 1'b0;
        half_period();
        send_cmd(0, 1'b1, 1'b1, 1'b1);
        read_bits(5, rx, oe_hi);
        check_eq("pre_rst_oe", 64'(miso_oe), 64'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_outs", 64'({miso, miso_oe, busy, cfg_valid, cfg_sgl, cfg_odd}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        base = cfg_pulses;
        mosi = 1'b0;
        read_bits(10, rx, oe_hi);
        check_eq("post_rst_oe_bits", 64'(oe_hi), 64'd0);
        end_xfer("post_rst");
        check_eq("post_rst_cfg_cnt", 64'(cfg_pulses - base), 64'd0);
        ch0_data = 12'h5A5; ch1_data = 12'h000;
        xfer("after_rst", 0, 1'b1, 1'b0, 1'b1, 13, 64'({1'b0, 12'h5A5}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcp3202_responder.md
MCP3202_RESPONDER -- requirements
Module: mcp3202_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth on the sck, cs_n and mosi inputs (legal values 2..4).
REQ-002 SHALL have parameter MSBF_ALLOWED, default 1, meaning LSB-first readout is honoured when 1 and ignored when 0.
REQ-003 SHALL have port clk  input  1  system clock; it SHALL run at least 8x the SCK frequency.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sck  input  1  SPI clock from the ADC master, asynchronous to clk.
REQ-006 SHALL have port cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-007 SHALL have port mosi  input  1  SPI data from the master (device DIN).
REQ-008 SHALL have port miso  output  1  SPI data to the master (device DOUT).
REQ-009 SHALL have port miso_oe  output  1  DOUT drive enable; when 0 the pad is high-Z.
REQ-010 SHALL have port ch0_data  input  12  analog channel 0 code.
REQ-011 SHALL have port ch1_data  input  12  analog channel 1 code.
REQ-012 SHALL have port cfg_valid  output  1  one-clk pulse when the configuration bits are complete.
REQ-013 SHALL have port cfg_sgl  output  1  latched SGL/DIFF bit.
REQ-014 SHALL have port cfg_odd  output  1  latched ODD/SIGN bit.
REQ-015 SHALL have port busy  output  1  high while a transaction is in progress (cs_n low, synchronised).

Function
REQ-016 Inputs SHALL pass through SYNC_STAGES flops; SCK edges SHALL be detected from the last two synchronised samples.
REQ-017 The FSM SHALL have the states IDLE, WAIT_START, CFG, NULLB, DATA_MSB, DATA_LSB and TRAIL.
REQ-018 Synchronised cs_n high SHALL force IDLE, miso_oe=0, miso=0 and busy=0 within 1 clk, from any state.
REQ-019 On the cs_n falling edge, the FSM SHALL go IDLE->WAIT_START and set busy=1.
REQ-020 In WAIT_START, a rising SCK with mosi=1 SHALL be taken as the start bit and move the FSM to CFG; leading zeros SHALL be ignored.
REQ-021 CFG SHALL take 3 rising edges, capturing SGL, ODD and MSBF in that order.
REQ-022 On the third CFG rising edge the block SHALL: pulse cfg_valid; latch the sample value; enter NULLB.
REQ-023 The latched sample value SHALL be chosen as follows:
- SGL=1: ch0_data or ch1_data, selected by ODD.
- SGL=0, ODD=0: ch0_data-ch1_data, saturated at 0.
- SGL=0, ODD=1: ch1_data-ch0_data, saturated at 0.
- Width 12 unsigned.
REQ-024 Changes on ch0_data/ch1_data after the latch SHALL NOT affect the current transaction.
REQ-025 miso and miso_oe SHALL update only on synchronised SCK falling edges, with the update registered 1 clk after edge detection.
REQ-026 In NULLB, the first falling edge SHALL assert miso_oe=1 with miso=0.
REQ-027 DATA_MSB SHALL shift out B11..B0 on 12 consecutive falling edges.
REQ-028 After B0, the next state SHALL be:
- DATA_LSB if MSBF=0 and MSBF_ALLOWED=1, which shifts B1..B11 on 11 falling edges;
- TRAIL otherwise.
REQ-029 TRAIL SHALL drive miso=0 with miso_oe=1 until cs_n rises; extra SCK edges SHALL be harmless.
REQ-030 cs_n rising mid-transaction SHALL abort with no cfg_valid; a new cs_n fall SHALL restart cleanly.

Reset
REQ-031 On reset the block SHALL set: state IDLE, miso=0, miso_oe=0, busy=0, cfg_valid=0, cfg_sgl=0, cfg_odd=0, the latched sample to 0, and all synchroniser flops to cs_n=1, sck=0, mosi=0.
REQ-032 Deassertion of reset SHALL produce no spurious SCK or cs_n edge.

Structure
REQ-033 FSM state enum and bit counts (CFG_BITS=3, DATA_BITS=12) SHALL be placed in the shared package mcp3202_pkg.
REQ-034 One sub-module, sync_edge (N-stage synchroniser with rise/fall pulse outputs), SHALL be instantiated 3 times; all other logic SHALL be in a single process domain on clk.

Verification
REQ-035 Scenario: clk 135 MHz, SCK 0.9 MHz, mosi bits 1,1,0,1, ch0=0xABC -> cfg_valid once with sgl=1, odd=0; miso gives null 0 then 101010111100; then zeros.
REQ-036 Scenario: as REQ-035 but ODD=1, ch1=0x001 -> 000000000001 after the null bit.
REQ-037 Scenario: SGL=0, ODD=0, ch0=0x100, ch1=0x200 -> 0x000; SGL=0, ODD=1 -> 0x100.
REQ-038 Scenario: MSBF=0, sample 0x801 -> 100000000001 followed by 00000000001 (B1..B11).
REQ-039 Scenario: cs_n raised after 6 data bits, then a full new transaction -> miso_oe=0 within SYNC_STAGES+2 clk; second transaction correct.
REQ-040 Scenario: reset asserted mid-DATA_MSB -> all outputs at reset values asynchronously; no cfg_valid until the next complete start sequence.
